// File: rtl/counter_mod.sv
// -----------------------------------------------------------------------------
// counter_mod
//
// Parametrised modulo counter for the low-rate timebase domain. Counts in the
// range 0..MODULO-1, up or down, gated by an enable and a clock prescaler, with
// synchronous clear, clamped parallel load and a registered one-cycle
// terminal-count pulse that can drive the enable of a cascaded stage.
//
// Parameters:
//   WIDTH    - counter width in bits
//   MODULO   - count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   PRESCALE - enabled clk cycles per count step (>= 1)
//
// Ports:
//   clk      - sole clock, all state updates on its rising edge
//   rst      - asynchronous active-high reset
//   en       - count enable; low freezes counter and prescaler
//   up       - direction, 1 = increment, 0 = decrement (used on step cycles)
//   clr      - synchronous clear (beats load and step)
//   load     - synchronous parallel load (beats step)
//   load_val - load value, clamped to MODULO-1
//   cnt      - current count, registered
//   tc       - terminal-count pulse, registered, one clk wide
//
// Build option:
//   COUNTER_MOD_SAT_EN - when defined, the counter saturates at the boundary
//   instead of wrapping; tc still pulses for every step attempted there.
// -----------------------------------------------------------------------------
module counter_mod #(
    parameter int WIDTH    = 16,
    parameter int MODULO   = 65536,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    // Prescaler is at least one bit wide so PRESCALE = 1 still has a legal
    // (constant-zero) register and the step condition degenerates to en.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Count arithmetic is carried one bit wider than cnt so MODULO = 2**WIDTH
    // is representable and comparisons never truncate.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    // Elaboration-time parameter legality checks.
    generate
        if (MODULO < 2 || (WIDTH < 31 && MODULO > (1 << WIDTH))) begin : g_bad_modulo
            $error("counter_mod: MODULO out of range for WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("counter_mod: PRESCALE must be >= 1");
        end
    endgenerate

    logic [PS_W-1:0]  ps;
    logic             step;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH-1:0] step_cnt;
    logic             step_tc;
    logic [WIDTH-1:0] load_clamped;

    assign cnt_ext = {1'b0, cnt};

    // A step fires on the enabled cycle that completes a prescale period.
    assign step = en && (ps == PS_LAST);

    // Out-of-range loads land on the top of the count range.
    assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_EXT[WIDTH-1:0];

    // Value and terminal-count flag that a step would produce this cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        step_cnt = cnt;
        step_tc  = 1'b0;
        if (up) begin
            if (cnt_ext == MAX_EXT) begin
                step_tc = 1'b1;
`ifdef COUNTER_MOD_SAT_EN
                step_cnt = cnt;
`else
                step_cnt = '0;
`endif
            end else begin
                step_cnt = WIDTH'(cnt_ext + ONE_EXT);
            end
        end else begin
            if (cnt_ext == '0) begin
                step_tc = 1'b1;
`ifdef COUNTER_MOD_SAT_EN
                step_cnt = cnt;
`else
                step_cnt = MAX_EXT[WIDTH-1:0];
`endif
            end else begin
                step_cnt = WIDTH'(cnt_ext - ONE_EXT);
            end
        end
    end

    // Priority: rst > clr > load > step. tc is cleared on every edge that is
    // not a boundary step, which makes it a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b0;
            ps  <= '0;
        end else if (clr) begin
            cnt <= '0;
            tc  <= 1'b0;
            ps  <= '0;
        end else if (load) begin
            cnt <= load_clamped;
            tc  <= 1'b0;
            ps  <= '0;
        end else if (step) begin
            cnt <= step_cnt;
            tc  <= step_tc;
            ps  <= '0;
        end else begin
            tc <= 1'b0;
            // Prescaler only advances on enabled cycles, so pausing en never
            // loses or duplicates a step.
            if (en) begin
                ps <= ps + PS_ONE;
            end
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_mod
//
// Self-checking bench for counter_mod. Three instances share the stimulus:
//   dut_a: WIDTH=4,  MODULO=10,    PRESCALE=1 (table-driven vectors)
//   dut_b: WIDTH=4,  MODULO=10,    PRESCALE=3 (prescaler / enable / direction)
//   dut_c: defaults (WIDTH=16, MODULO=65536, PRESCALE=1)
// Each sequence starts from a load or clear so the unobserved instances never
// affect expectations.
// -----------------------------------------------------------------------------
module tb_counter_mod;

`ifdef COUNTER_MOD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [3:0]  cnt_a;
    logic        tc_a;
    logic [3:0]  cnt_b;
    logic        tc_b;
    logic [15:0] cnt_c;
    logic        tc_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .cnt(cnt_a), .tc(tc_a)
    );

    counter_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .cnt(cnt_b), .tc(tc_b)
    );

    counter_mod dut_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt_c), .tc(tc_c)
    );

    typedef struct {
        logic        en;
        logic        up;
        logic        clr;
        logic        load;
        logic [15:0] load_val;
        logic [3:0]  exp_cnt;      // wrapping build
        logic [3:0]  exp_cnt_sat;  // saturating build
        logic        exp_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic e, input logic u, input logic c, input logic l, input logic [15:0] lv);
        en = e; up = u; clr = c; load = l; load_val = lv;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic u, input logic c, input logic l,
                       input logic [15:0] lv, input logic [3:0] ec, input logic [3:0] ecs,
                       input logic et);
        vec_t v;
        v.en = e; v.up = u; v.clr = c; v.load = l; v.load_val = lv;
        v.exp_cnt = ec; v.exp_cnt_sat = ecs; v.exp_tc = et;
        vecs.push_back(v);
    endtask

    initial begin
        // Test 1: up count 0..9 then wrap (dut_a starts at 0 after async reset)
        for (int i = 1; i <= 9; i++) add(1, 1, 0, 0, 0, 4'(i), 4'(i), 0);
        add(1, 1, 0, 0, 0, 0, 9, 1);
        // Test 2: load 2, count down through 0
        add(0, 0, 0, 1, 2, 2, 2, 0);
        add(1, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 9, 0, 1);
        // en low: hold, tc drops
        add(0, 1, 0, 0, 0, 9, 0, 0);
        // Test 4: priority clr > load > step
        add(0, 1, 0, 1, 5, 5, 5, 0);
        add(1, 1, 1, 1, 7, 0, 0, 0);
        add(0, 1, 0, 1, 7, 7, 7, 0);
        // Test 5: load clamp then step at top
        add(0, 1, 0, 1, 15, 9, 9, 0);
        add(1, 1, 0, 0, 0, 0, 9, 1);
        add(0, 1, 0, 0, 0, 0, 9, 0);

        rst = 1'b1;
        drive(0, 1, 0, 0, 0);

        // Reset state
        tick();
        tick();
        check("rst cnt_a", 32'(cnt_a), 0);
        check("rst tc_a", 32'(tc_a), 0);
        check("rst cnt_b", 32'(cnt_b), 0);
        check("rst cnt_c", 32'(cnt_c), 0);
        check("rst tc_c", 32'(tc_c), 0);
        rst = 1'b0;

        // Count a few steps, then pulse rst between edges
        drive(1, 1, 0, 0, 0);
        repeat (3) tick();
        check("pre-rst cnt_a", 32'(cnt_a), 3);
        drive(0, 1, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        check("async rst cnt_a", 32'(cnt_a), 0);
        check("async rst tc_a", 32'(tc_a), 0);
        check("async rst cnt_c", 32'(cnt_c), 0);
        #1 rst = 1'b0;

        // Table-driven vectors on dut_a
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].load, vecs[i].load_val);
            tick();
            check($sformatf("vec%0d cnt_a", i), 32'(cnt_a),
                  32'(SAT ? vecs[i].exp_cnt_sat : vecs[i].exp_cnt));
            check($sformatf("vec%0d tc_a", i), 32'(tc_a), 32'(vecs[i].exp_tc));
        end

        // Test 3: prescaler = 3 on dut_b
        drive(0, 1, 1, 0, 0);
        tick();
        check("b clr", 32'(cnt_b), 0);
        drive(1, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("b ps cyc%0d", i), 32'(cnt_b), 32'(i / 3));
        end
        repeat (2) tick();
        check("b mid-prescale", 32'(cnt_b), 3);
        drive(0, 1, 0, 0, 0);
        repeat (5) tick();
        check("b en low hold", 32'(cnt_b), 3);
        check("b en low tc", 32'(tc_b), 0);
        drive(1, 1, 0, 0, 0);
        tick();
        check("b resume step", 32'(cnt_b), 4);

        // Direction flip mid-prescale on dut_b
        drive(0, 1, 0, 1, 5);
        tick();
        check("b load 5", 32'(cnt_b), 5);
        drive(1, 1, 0, 0, 0);
        tick();
        check("b ps1", 32'(cnt_b), 5);
        drive(1, 0, 0, 0, 0);
        tick();
        check("b ps2", 32'(cnt_b), 5);
        tick();
        check("b flip down", 32'(cnt_b), 4);

        // Test 6: default parameters on dut_c
        drive(0, 1, 0, 1, 16'hFFFF);
        tick();
        check("c load max", 32'(cnt_c), 65535);
        drive(1, 1, 0, 0, 0);
        tick();
        check("c wrap cnt", 32'(cnt_c), SAT ? 65535 : 0);
        check("c wrap tc", 32'(tc_c), 1);
        drive(1, 0, 0, 0, 0);
        tick();
        check("c down cnt", 32'(cnt_c), SAT ? 65534 : 65535);
        check("c down tc", 32'(tc_c), SAT ? 0 : 1);
        drive(0, 0, 0, 0, 0);
        tick();
        check("c tc clear", 32'(tc_c), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
